// File: rtl/route_table_responder.sv
// Route-record responder: scans per-record shadow keys for a match, serves one-cycle word reads, takes host writes.
// Optional feature: define ROUTE_DEFAULT_EN to report a miss as a hit on DEFAULT_BASE.
module route_table_responder #(
   parameter int MEMLEN       = 32,
   parameter int MEMDEPTH     = 512,
   parameter int MEMDBITS     = 9,
   parameter int NREC         = MEMDEPTH / 5,
   parameter int DEFAULT_BASE = 0
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                match_enable,
   input  logic [MEMLEN-1:0]   data_in,
   input  logic                read_enable,
   input  logic [MEMDBITS-1:0] read_address,
   input  logic                wr_en,
   input  logic [MEMDBITS-1:0] wr_addr,
   input  logic [MEMLEN-1:0]   wr_data,
   input  logic                clear_all,
   output logic [MEMLEN-1:0]   read_data,
   output logic                match_found,
   output logic                match_miss,
   output logic                busy
);
   localparam int                IDXW      = (NREC > 1) ? $clog2(NREC) : 1;
   localparam logic [IDXW-1:0]   LAST_IDX  = IDXW'(NREC - 1);
   localparam logic [MEMDBITS:0] DEPTH_LIM = (MEMDBITS + 1)'(MEMDEPTH);
`ifdef ROUTE_DEFAULT_EN
   localparam bit DEFAULT_EN = 1'b1;
`else
   localparam bit DEFAULT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SCAN, HIT, MISS} state_t;

   state_t            state_q;
   logic [IDXW-1:0]   idx_q;
   logic [MEMLEN-1:0] key_q;
   logic [MEMLEN-1:0] result_q;
   logic [MEMLEN-1:0] rd_word_q;
   logic              sel_mem_q;
   logic              rd_oob_q;
   logic              match_found_q;
   logic              match_miss_q;

   logic [MEMLEN-1:0] mem [MEMDEPTH];
   logic [MEMLEN-1:0] shadow_q [NREC];
   logic [NREC-1:0]   valid_q;

   logic [NREC-1:0]   rec_wr_d;
   logic              wr_ok_d;
   logic              rd_fire_d;
   logic              key_hit_d;
   logic [MEMLEN-1:0] idx_ext_d;
   logic [MEMLEN-1:0] base_d;

   assign wr_ok_d   = wr_en && ({1'b0, wr_addr} < DEPTH_LIM);
   assign rd_fire_d = (state_q == IDLE) && read_enable && !match_enable;

   // One decoder per record: a write lands on record gi only at its base word 5*gi.
   generate
      for (genvar gi = 0; gi < NREC; gi++) begin : g_rec_dec
         localparam logic [MEMDBITS-1:0] REC_BASE = MEMDBITS'(5 * gi);
         assign rec_wr_d[gi] = wr_en && (wr_addr == REC_BASE);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr_ok_d) mem[wr_addr] <= wr_data;
      if (rd_fire_d) rd_word_q <= mem[read_address];
   end

   // clear_all beats a same-cycle write to the valid bit; the shadow key still updates.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREC; i++) begin
         if (rec_wr_d[i]) shadow_q[i] <= wr_data;
         if (!resetn || clear_all) valid_q[i] <= 1'b0;
         else if (rec_wr_d[i])     valid_q[i] <= 1'b1;
      end
   end

   assign key_hit_d = valid_q[idx_q] && (shadow_q[idx_q] == key_q);
   assign idx_ext_d = MEMLEN'(idx_q);
   assign base_d    = (idx_ext_d << 2) + idx_ext_d;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         result_q      <= '0;
         sel_mem_q     <= 1'b0;
         rd_oob_q      <= 1'b0;
         match_found_q <= 1'b0;
         match_miss_q  <= 1'b0;
      end else begin
         match_found_q <= 1'b0;
         match_miss_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (match_enable) begin
                  key_q   <= data_in;
                  idx_q   <= '0;
                  state_q <= SCAN;
               end else if (read_enable) begin
                  sel_mem_q <= 1'b1;
                  rd_oob_q  <= ({1'b0, read_address} >= DEPTH_LIM);
               end
            end
            SCAN: begin
               if (key_hit_d)              state_q <= HIT;
               else if (idx_q == LAST_IDX) state_q <= MISS;
               else                        idx_q   <= idx_q + 1'b1;
            end
            HIT: begin
               match_found_q <= 1'b1;
               result_q      <= base_d;
               sel_mem_q     <= 1'b0;
               state_q       <= IDLE;
            end
            MISS: begin
               if (DEFAULT_EN) begin
                  match_found_q <= 1'b1;
                  result_q      <= MEMLEN'(DEFAULT_BASE);
                  sel_mem_q     <= 1'b0;
               end else begin
                  match_miss_q  <= 1'b1;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign read_data   = sel_mem_q ? (rd_oob_q ? '0 : rd_word_q) : result_q;
   assign match_found = match_found_q;
   assign match_miss  = match_miss_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_route_table_responder.sv
// Self-checking bench for route_table_responder: vector table, corner-case sequences, random ops vs. a record-level model.
module tb_route_table_responder;
   localparam int MEMLEN   = 32;
   localparam int MEMDEPTH = 512;
   localparam int MEMDBITS = 9;
   localparam int NREC     = 102;
`ifdef ROUTE_DEFAULT_EN
   localparam bit DEF_EN = 1'b1;
`else
   localparam bit DEF_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                resetn = 1'b0;
   logic                match_enable = 1'b0;
   logic [MEMLEN-1:0]   data_in = '0;
   logic                read_enable = 1'b0;
   logic [MEMDBITS-1:0] read_address = '0;
   logic                wr_en = 1'b0;
   logic [MEMDBITS-1:0] wr_addr = '0;
   logic [MEMLEN-1:0]   wr_data = '0;
   logic                clear_all = 1'b0;
   logic [MEMLEN-1:0]   read_data;
   logic                match_found;
   logic                match_miss;
   logic                busy;

   route_table_responder #(
      .MEMLEN(MEMLEN), .MEMDEPTH(MEMDEPTH), .MEMDBITS(MEMDBITS), .NREC(NREC), .DEFAULT_BASE(0)
   ) dut (
      .clk(clk), .resetn(resetn), .match_enable(match_enable), .data_in(data_in),
      .read_enable(read_enable), .read_address(read_address), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .clear_all(clear_all),
      .read_data(read_data), .match_found(match_found), .match_miss(match_miss), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: flat word memory plus record keys/valid bits.
   logic [31:0] m_mem [MEMDEPTH];
   logic [31:0] m_key [NREC];
   bit          m_valid [NREC];
   logic [31:0] exp_rd = '0;

   typedef struct {
      int          op;    // 0 write, 1 read (data = expected word), 2 match (data = key)
      logic [8:0]  addr;
      logic [31:0] data;
      int          exp_k; // expected record index for a match, -1 for miss
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic int model_match(input logic [31:0] key);
      for (int k = 0; k < NREC; k++)
         if (m_valid[k] && m_key[k] === key) return k;
      return -1;
   endfunction

   function automatic void model_write(input logic [8:0] a, input logic [31:0] d);
      int ai;
      ai = int'(a);
      if (ai < MEMDEPTH) m_mem[ai] = d;
      if (ai % 5 == 0 && ai / 5 < NREC) begin
         m_key[ai/5]   = d;
         m_valid[ai/5] = 1'b1;
      end
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < NREC; k++) m_valid[k] = 1'b0;
   endfunction

   task automatic do_write(input logic [8:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
      model_write(a, d);
   endtask

   task automatic do_clear();
      clear_all = 1'b1;
      tick();
      clear_all = 1'b0;
      model_clear();
   endtask

   task automatic do_read(input logic [8:0] a, input logic [31:0] want, input string name);
      read_enable = 1'b1; read_address = a;
      tick();
      read_enable = 1'b0;
      exp_rd = want;
      $display("read  %s addr=%0d data=%h", name, a, read_data);
      check(name, read_data, want);
   endtask

   // inj_kind: 0 none, 1 host write at cycle inj_n, 2 stray match_enable+read_enable at cycle inj_n
   task automatic run_match(input logic [31:0] key, input int exp_k, input int inj_n, input int inj_kind,
                            input logic [8:0] inj_a, input logic [31:0] inj_d, input string name);
      int          n;
      int          got_n;
      int          want_n;
      bit          busy_ok;
      bit          hold_ok;
      logic [1:0]  got_flags;
      logic [1:0]  want_flags;
      logic [31:0] rd_before;
      logic [31:0] want_rd;
      rd_before = exp_rd;
      data_in = key; match_enable = 1'b1;
      tick();
      match_enable = 1'b0;
      n = 0; got_n = -1; got_flags = 2'b00; busy_ok = busy; hold_ok = 1'b1;
      while (n < NREC + 8) begin
         if (n == inj_n && inj_kind == 1) begin
            wr_en = 1'b1; wr_addr = inj_a; wr_data = inj_d;
         end
         if (n == inj_n && inj_kind == 2) begin
            match_enable = 1'b1; data_in = inj_d; read_enable = 1'b1; read_address = inj_a;
         end
         tick();
         n++;
         if (n == inj_n + 1 && inj_kind == 1) begin
            wr_en = 1'b0;
            model_write(inj_a, inj_d);
         end
         match_enable = 1'b0; read_enable = 1'b0;
         if (match_found || match_miss) begin
            got_n = n; got_flags = {match_found, match_miss};
            break;
         end
         if (!busy) busy_ok = 1'b0;
         if (read_data !== rd_before) hold_ok = 1'b0;
      end
      want_n     = (exp_k >= 0) ? 2 + exp_k : NREC + 1;
      want_flags = (exp_k >= 0 || DEF_EN) ? 2'b10 : 2'b01;
      want_rd    = (exp_k >= 0) ? 32'(5 * exp_k) : (DEF_EN ? 32'd0 : rd_before);
      $display("match %s key=%h pulse_cycle=%0d flags=%b read_data=%h", name, key, got_n, got_flags, read_data);
      check({name, " cycle"}, 32'(got_n), 32'(want_n));
      check({name, " flags"}, {30'd0, got_flags}, {30'd0, want_flags});
      check({name, " read_data"}, read_data, want_rd);
      check({name, " busy_during"}, {31'd0, busy_ok}, 32'd1);
      check({name, " hold"}, {31'd0, hold_ok}, 32'd1);
      check({name, " busy_at_pulse"}, {31'd0, busy}, 32'd0);
      exp_rd = want_rd;
      tick();
      check({name, " pulse_width"}, {30'd0, match_found, match_miss}, 32'd0);
   endtask

   vec_t vecs [15];
   logic [31:0] pool [6];
   bit          pulse_seen;

   initial begin
      vecs[0]  = '{0, 9'd10, 32'hC0A80001, 0};
      vecs[1]  = '{0, 9'd11, 32'h0A000002, 0};
      vecs[2]  = '{0, 9'd12, 32'h00112233, 0};
      vecs[3]  = '{0, 9'd13, 32'h44550050, 0};
      vecs[4]  = '{0, 9'd14, 32'h00000003, 0};
      vecs[5]  = '{2, 9'd0,  32'hC0A80001, 2};
      vecs[6]  = '{1, 9'd11, 32'h0A000002, 0};
      vecs[7]  = '{1, 9'd12, 32'h00112233, 0};
      vecs[8]  = '{1, 9'd13, 32'h44550050, 0};
      vecs[9]  = '{1, 9'd14, 32'h00000003, 0};
      vecs[10] = '{1, 9'd10, 32'hC0A80001, 0};
      vecs[11] = '{0, 9'd15, 32'h5A5A0003, 0};
      vecs[12] = '{0, 9'd35, 32'h5A5A0003, 0};
      vecs[13] = '{2, 9'd0,  32'h5A5A0003, 3};
      vecs[14] = '{2, 9'd0,  32'hDEADBEEF, -1};
      for (int i = 0; i < 6; i++) pool[i] = 32'h1000_0000 + 32'(i);
      model_clear();

      // Reset state
      repeat (3) tick();
      resetn = 1'b1;
      check("reset read_data", read_data, 32'd0);
      check("reset found", {31'd0, match_found}, 32'd0);
      check("reset miss", {31'd0, match_miss}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);

      // All records invalid after reset
      run_match(32'hDEADBEEF, -1, -1, 0, 9'd0, 32'd0, "post_reset_miss");

      // Give every word and shadow key a known value, then invalidate everything
      for (int a = 0; a < MEMDEPTH; a++) do_write(9'(a), 32'hF000_0000 | 32'(a));
      do_clear();

      for (int i = 0; i < 15; i++) begin
         case (vecs[i].op)
            0: do_write(vecs[i].addr, vecs[i].data);
            1: do_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
            default: run_match(vecs[i].data, vecs[i].exp_k, -1, 0, 9'd0, 32'd0, $sformatf("vec%0d", i));
         endcase
      end

      do_clear();
      run_match(32'h5A5A0003, -1, -1, 0, 9'd0, 32'd0, "after_clear");

      // clear_all and a record write in the same cycle: data lands, record stays invalid
      wr_en = 1'b1; wr_addr = 9'd40; wr_data = 32'h4040_4040; clear_all = 1'b1;
      tick();
      wr_en = 1'b0; clear_all = 1'b0;
      model_write(9'd40, 32'h4040_4040);
      model_clear();
      run_match(32'h4040_4040, -1, -1, 0, 9'd0, 32'd0, "clear_vs_write");
      do_read(9'd40, 32'h4040_4040, "clear_vs_write_word");

      // Stray match_enable/read_enable during SCAN are ignored
      do_write(9'd150, 32'h7777_0030);
      run_match(32'h7777_0030, 30, 5, 2, 9'd100, 32'h4040_4040, "stray_inputs");

      // Writes during SCAN: ahead of idx counts, behind idx does not
      run_match(32'h3333_0050, 50, 20, 1, 9'd250, 32'h3333_0050, "write_ahead");
      run_match(32'h3333_0005, -1, 20, 1, 9'd25, 32'h3333_0005, "write_behind");

      // Same-cycle read and write of one address returns the old word
      wr_en = 1'b1; wr_addr = 9'd100; wr_data = 32'hABCD_0100;
      read_enable = 1'b1; read_address = 9'd100;
      tick();
      wr_en = 1'b0; read_enable = 1'b0;
      $display("read  rw_same addr=100 data=%h", read_data);
      check("rw_same old", read_data, m_mem[100]);
      model_write(9'd100, 32'hABCD_0100);
      do_read(9'd100, 32'hABCD_0100, "rw_same new");

      // Reset mid-SCAN aborts with no result pulse
      data_in = 32'h7777_0030; match_enable = 1'b1;
      tick();
      match_enable = 1'b0;
      repeat (10) tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      model_clear();
      exp_rd = 32'd0;
      check("midscan_reset busy", {31'd0, busy}, 32'd0);
      check("midscan_reset read_data", read_data, 32'd0);
      pulse_seen = 1'b0;
      for (int c = 0; c < NREC + 5; c++) begin
         if (match_found || match_miss) pulse_seen = 1'b1;
         tick();
      end
      check("midscan_reset no_pulse", {31'd0, pulse_seen}, 32'd0);
      run_match(32'h7777_0030, -1, -1, 0, 9'd0, 32'd0, "midscan_reset_invalid");

      // Randomized operations against the model
      for (int it = 0; it < 40; it++) begin
         int          r;
         int          k;
         logic [8:0]  a;
         logic [31:0] key;
         r = $urandom_range(0, 9);
         if (it == 20) begin
            do_clear();
         end else if (r < 4) begin
            k = $urandom_range(0, NREC - 1);
            do_write(9'(5 * k), pool[$urandom_range(0, 5)]);
         end else if (r < 6) begin
            a = 9'($urandom_range(0, MEMDEPTH - 1));
            do_write(a, $urandom);
         end else if (r < 8) begin
            a = 9'($urandom_range(0, MEMDEPTH - 1));
            do_read(a, m_mem[int'(a)], $sformatf("rnd_read%0d", it));
         end else begin
            key = pool[$urandom_range(0, 5)];
            run_match(key, model_match(key), -1, 0, 9'd0, 32'd0, $sformatf("rnd_match%0d", it));
         end
      end
      for (int i = 0; i < 6; i++)
         run_match(pool[i], model_match(pool[i]), -1, 0, 9'd0, 32'd0, $sformatf("pool%0d", i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
